// File: rtl/cen_gen.sv
// cen_gen: runtime-programmable fractional clock-enable generator.
// Derives CHANNELS phase-aligned enable streams from refclk. Each channel
// runs a Bresenham accumulator so its average enable rate is
// f_refclk * NUM / DEN. After reset or a config load, a lock counter holds
// every channel idle for LOCK_CYCLES edges. The accumulators then start
// together, which keeps the channels phase-aligned.
//
// Ports:
//   refclk   - system clock, rising edge
//   rst      - asynchronous active-low reset
//   cfg_num  - packed numerators (channel 0 in the LSBs), taken on cfg_load
//   cfg_den  - packed denominators, taken on cfg_load
//   cfg_load - one-cycle strobe: latch config, restart and relock
//   pause    - freeze accumulators and suppress enables
//   cen      - per-channel registered enable pulses
//   locked   - enables are valid and phase-aligned
//   cfg_err  - per-channel illegal configuration (den==0 or num>den)

// Per-channel shadow config, accumulator and enable register.
module cen_gen_ch #(
    parameter int              ACC_W   = 16,
    parameter logic [ACC_W-1:0] DEF_NUM = '0,
    parameter logic [ACC_W-1:0] DEF_DEN = '0
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             load,
    input  logic             locked,
    input  logic             pause,
    input  logic [ACC_W-1:0] load_num,
    input  logic [ACC_W-1:0] load_den,
    output logic             cen,
    output logic             err
);
    logic [ACC_W-1:0] num, den, acc;
    logic [ACC_W:0]   sum;
    logic             wrap;

    // The sum is compared at ACC_W+1 bits so that acc+num cannot overflow.
    // Both update candidates are exact in ACC_W bits: when wrapping, the
    // true result is below den; otherwise it is below den as well.
    assign sum  = {1'b0, acc} + {1'b0, num};
    assign wrap = sum >= {1'b0, den};
    assign err  = (den == '0) || (num > den);

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            num <= DEF_NUM;
            den <= DEF_DEN;
            acc <= '0;
            cen <= 1'b0;
        end else if (load) begin
            num <= load_num;
            den <= load_den;
            acc <= '0;
            cen <= 1'b0;
        end else if (!locked || err) begin
            acc <= '0;
            cen <= 1'b0;
        end else if (pause) begin
            cen <= 1'b0;
        end else if (wrap) begin
            acc <= acc + num - den;
            cen <= 1'b1;
        end else begin
            acc <= acc + num;
            cen <= 1'b0;
        end
    end
endmodule

module cen_gen #(
    parameter int                         CHANNELS    = 2,
    parameter int                         ACC_W       = 16,
    parameter logic [CHANNELS*ACC_W-1:0]  DEF_NUM     = {16'd1, 16'd1},
    parameter logic [CHANNELS*ACC_W-1:0]  DEF_DEN     = {16'd3, 16'd16},
    parameter int                         LOCK_CYCLES = 16
) (
    input  logic                      refclk,
    input  logic                      rst,
    input  logic [CHANNELS*ACC_W-1:0] cfg_num,
    input  logic [CHANNELS*ACC_W-1:0] cfg_den,
    input  logic                      cfg_load,
    input  logic                      pause,
    output logic [CHANNELS-1:0]       cen,
    output logic                      locked,
    output logic [CHANNELS-1:0]       cfg_err
);
    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    logic [CNT_W-1:0] lock_cnt;

    // Lock counts edges regardless of pause. The edge that brings the count
    // to LOCK_CYCLES sets locked. The first accumulator update therefore
    // lands on the following edge.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (cfg_load) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (!locked) begin
            lock_cnt <= lock_cnt + 1'b1;
            if (lock_cnt == CNT_W'(LOCK_CYCLES - 1))
                locked <= 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        cen_gen_ch #(
            .ACC_W  (ACC_W),
            .DEF_NUM(DEF_NUM[i*ACC_W +: ACC_W]),
            .DEF_DEN(DEF_DEN[i*ACC_W +: ACC_W])
        ) u_ch (
            .refclk  (refclk),
            .rst     (rst),
            .load    (cfg_load),
            .locked  (locked),
            .pause   (pause),
            .load_num(cfg_num[i*ACC_W +: ACC_W]),
            .load_den(cfg_den[i*ACC_W +: ACC_W]),
            .cen     (cen[i]),
            .err     (cfg_err[i])
        );
    end
endmodule

// File: tb/tb_cen_gen.sv
module tb_cen_gen;
    logic        refclk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cfg_num = '0;
    logic [31:0] cfg_den = '0;
    logic        cfg_load = 1'b0;
    logic        pause = 1'b0;
    logic [1:0]  cen;
    logic        locked;
    logic [1:0]  cfg_err;

    int checks = 0;
    int errors = 0;

    cen_gen dut (
        .refclk  (refclk),
        .rst     (rst),
        .cfg_num (cfg_num),
        .cfg_den (cfg_den),
        .cfg_load(cfg_load),
        .pause   (pause),
        .cen     (cen),
        .locked  (locked),
        .cfg_err (cfg_err)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic [31:0] num;
        logic [31:0] den;
        int          cyc;
        int          p0;
        int          p1;
        logic [1:0]  err;
        int          gmin;   // 0: no ch0 gap check
        int          gmax;
    } vec_t;

    vec_t tv[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] n, input logic [31:0] d);
        cfg_num  = n;
        cfg_den  = d;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic wait_lock(input string tag);
        int early = 0;
        repeat (15) begin
            step();
            if (locked) early++;
        end
        check({tag, " locked_early"}, early, 0);
        step();
        check({tag, " locked_at_16"}, int'(locked), 1);
    endtask

    task automatic run(input int n, output int p0, output int p1,
                       output int gmin, output int gmax);
        int last = -1;
        p0 = 0; p1 = 0; gmin = 1 << 30; gmax = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (cen[0]) begin
                p0++;
                if (last >= 0) begin
                    if (i - last < gmin) gmin = i - last;
                    if (i - last > gmax) gmax = i - last;
                end
                last = i;
            end
            if (cen[1]) p1++;
        end
    endtask

    // Update index (1-based) of the first ch0, ch1 and joint pulse; -1 if none.
    task automatic first_pulses(output int f0, output int f1, output int fb);
        f0 = -1; f1 = -1; fb = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (cen[0] && f0 < 0) f0 = i;
            if (cen[1] && f1 < 0) f1 = i;
            if (cen == 2'b11 && fb < 0) fb = i;
        end
    endtask

    initial begin
        int p0, p1, gmin, gmax, f0, f1, fb, bad, wait_n;

        //                num                den                cyc  p0   p1   err    gmin gmax
        tv[0] = '{{16'd1, 16'd1}, {16'd3, 16'd16}, 48,  3,   16,  2'b00, 16,  16};
        tv[1] = '{{16'd1, 16'd3}, {16'd3, 16'd8},  800, 300, 266, 2'b00, 2,   3};
        tv[2] = '{{16'd0, 16'd8}, {16'd5, 16'd8},  20,  20,  0,   2'b00, 1,   1};
        tv[3] = '{{16'd1, 16'd1}, {16'd0, 16'd16}, 32,  2,   0,   2'b10, 16,  16};
        tv[4] = '{{16'd5, 16'd2}, {16'd4, 16'd5},  25,  10,  0,   2'b10, 2,   3};
        tv[5] = '{{16'd1, 16'd7}, {16'd2, 16'd6},  20,  0,   10,  2'b01, 0,   0};
        tv[6] = '{{16'd1, 16'd1}, {16'd3, 16'd16}, 48,  3,   16,  2'b00, 16,  16};

        // Reset state and default startup
        repeat (3) step();
        check("rst cen", int'(cen), 0);
        check("rst locked", int'(locked), 0);
        check("rst cfg_err", int'(cfg_err), 0);
        rst = 1'b1;
        wait_lock("reset");
        first_pulses(f0, f1, fb);
        check("reset first ch0", f0, 16);
        check("reset first ch1", f1, 3);
        check("reset first joint", fb, 48);

        // Table-driven configurations
        for (int v = 0; v < 7; v++) begin
            do_load(tv[v].num, tv[v].den);
            check($sformatf("v%0d cen_after_load", v), int'(cen), 0);
            check($sformatf("v%0d locked_after_load", v), int'(locked), 0);
            check($sformatf("v%0d cfg_err", v), int'(cfg_err), int'(tv[v].err));
            wait_lock($sformatf("v%0d", v));
            run(tv[v].cyc, p0, p1, gmin, gmax);
            check($sformatf("v%0d ch0_pulses", v), p0, tv[v].p0);
            check($sformatf("v%0d ch1_pulses", v), p1, tv[v].p1);
            if (tv[v].gmin != 0) begin
                check($sformatf("v%0d ch0_gap_min", v), gmin, tv[v].gmin);
                check($sformatf("v%0d ch0_gap_max", v), gmax, tv[v].gmax);
            end
        end

        // Pause for 10 cycles after 8 updates of the den=16 period
        do_load({16'd1, 16'd1}, {16'd3, 16'd16});
        wait_lock("pause");
        repeat (8) step();
        pause = 1'b1;
        bad = 0;
        repeat (10) begin
            step();
            if (cen != 2'b00 || !locked) bad++;
        end
        check("pause quiet_and_locked", bad, 0);
        pause = 1'b0;
        step();
        check("pause resume ch1", int'(cen[1]), 1);
        wait_n = 1;
        while (!cen[0] && wait_n < 40) begin
            step();
            wait_n++;
        end
        check("pause resume ch0 delay", wait_n, 8);

        // cfg_load together with pause, mid-stream
        repeat (5) step();
        pause = 1'b1;
        do_load({16'd1, 16'd1}, {16'd3, 16'd16});
        check("loadpause locked", int'(locked), 0);
        check("loadpause cen", int'(cen), 0);
        wait_lock("loadpause");
        bad = 0;
        repeat (5) begin
            step();
            if (cen != 2'b00) bad++;
        end
        check("loadpause gated", bad, 0);
        pause = 1'b0;
        first_pulses(f0, f1, fb);
        check("loadpause first ch1", f1, 3);
        check("loadpause first joint", fb, 48);

        // Async reset between edges after a non-default load
        do_load({16'd1, 16'd1}, {16'd1, 16'd1});
        wait_lock("arst");
        repeat (3) step();
        check("arst cen_running", int'(cen), 3);
        #3;
        rst = 1'b0;
        #1;
        check("arst cen_immediate", int'(cen), 0);
        check("arst locked_immediate", int'(locked), 0);
        step();
        rst = 1'b1;
        wait_lock("arst_release");
        check("arst cfg_err", int'(cfg_err), 0);
        first_pulses(f0, f1, fb);
        check("arst default ch0", f0, 16);
        check("arst default joint", fb, 48);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cen_gen.md
Name: cen_gen

Overview:
- Parametrised, runtime-programmable fractional clock-enable generator. It derives CHANNELS phase-aligned clock-enable streams from one fast system clock.
- It replaces fixed PLL output taps for low-rate domains (e.g. 6 MHz and 32 MHz enables from a 96 MHz clock).
- Each channel produces an average enable rate of f_refclk·NUM/DEN using a Bresenham accumulator.
- A lock/ready handshake, pause and error reporting are provided. A fixed PLL has none of these.

Parameters:
CHANNELS, 2, number of independent enable channels (1..8)
ACC_W, 16, width of the NUM/DEN/accumulator fields per channel
DEF_NUM, {16'd1,16'd1}, packed reset NUM values; channel 0 in the LSBs
DEF_DEN, {16'd3,16'd16}, packed reset DEN values (96 MHz → ch0 6 MHz, ch1 32 MHz)
LOCK_CYCLES, 16, refclk cycles from reset release/load until locked asserts (≥1)

Ports:
refclk  in  1  system clock; all logic on its rising edge
rst  in  1  asynchronous, active-low reset
cfg_num  in  CHANNELS*ACC_W  packed numerators, sampled on cfg_load
cfg_den  in  CHANNELS*ACC_W  packed denominators, sampled on cfg_load
cfg_load  in  1  single-cycle strobe: latch cfg_num/cfg_den, restart all channels
pause  in  1  freeze all accumulators, suppress enables
cen  out  CHANNELS  per-channel clock-enable pulses, registered
locked  out  1  enables valid and phase-aligned
cfg_err  out  CHANNELS  per-channel illegal-configuration flag

Behaviour:
- Reset (rst=0, async): shadow num/den ← DEF_NUM/DEF_DEN; all acc ← 0; cen ← 0; cfg_err ← error decode of defaults; locked ← 0; lock counter ← 0.
- Lock counter: counts refclk edges after reset release or after any cfg_load, regardless of pause. The edge on which the count reaches LOCK_CYCLES sets locked=1. locked then stays 1 until the next reset or cfg_load.
- While locked=0: acc held at 0, cen=0.
- cfg_load, sampled high on edge k:
  - shadow regs ← cfg_num/cfg_den.
  - all acc ← 0, cen ← 0, locked ← 0, lock counter ← 0.
  - cfg_err recomputed from the new values, valid after edge k.
  - cfg_load overrides pause and any in-progress lock count.
- Channel i error condition: den==0 or num>den → cfg_err[i]=1. cen[i] is held 0 and acc[i] is held 0. Other channels are unaffected.
- Per-channel update, on each edge with locked=1, pause=0 and cfg_err[i]=0:
  - s = acc + num, computed at ACC_W+1 bits with no overflow.
  - if s ≥ den: acc ← s − den and cen[i] ← 1.
  - else: acc ← s and cen[i] ← 0.
  - Invariant: acc < den at all times.
- num==0 → cen[i] never asserts. num==den → cen[i]=1 on every cycle.
- Latency: the first accumulator update happens on the edge after the one that sets locked. With num=1 and den=D, the first cen pulse is registered on the D-th update edge. All channels share update edge 0, so cen streams coincide at multiples of LCM(D).
- pause=1: acc holds, cen ← 0 on the next edge. On deassert, the sequence resumes exactly where it stopped. Pause does not drop lock.
- A cfg_load arriving while paused reloads and relocks normally. pause still gates updates once locked.
- Widths: shadow regs ACC_W each; acc ACC_W bits; compare at ACC_W+1 bits.

Test Plan:
- Reset defaults, pause=0: locked rises 16 cycles after rst release. Then cen[1] is high 1 of every 3 cycles and cen[0] 1 of every 16; both first pulse together at update 48, and cfg_err=0.
- Load ch0 num=3 den=8: over 800 locked cycles exactly 300 cen[0] pulses, with pulse gaps only 2 or 3 cycles. Load num=8 den=8: cen[0]=1 every cycle.
- pause for 10 cycles in the middle of a den=16 period: no cen during pause. The next pulse arrives 10 cycles later than in the unpaused reference, and locked stays 1.
- Load ch1 den=0, then num=5 den=4: cfg_err[1]=1 and cen[1] stuck 0, while ch0 runs normally. Load a legal config: cfg_err[1] clears.
- cfg_load asserted mid-stream and simultaneously with pause=1: locked drops the next cycle, cen=0, and relock takes 16 cycles. Channels restart phase-aligned from acc=0.
- Async rst asserted mid-stream, away from any edge: cen=0 and locked=0 immediately. Shadow regs return to DEF values even after an earlier cfg_load.
